passcode_access_ctrl: RTL
=========================

Name: passcode_access_ctrl

Overview:
- Supervisory controller that sequences the 4-digit passcode checker FSM.
- Supplies the checker's whole-second entry timer and tracks entry sessions, counting consecutive failures.
- Enforces a timed lockout by masking the checker's button after MAX_FAILS failures, and reports unlocked/lockout status to top-level LEDs.
- Sits between the board button (btn0, active-low) and the checker.

Parameters:
- CLK_HZ, 50000000, clk cycles per second tick.
- ENTRY_TIMEOUT_S, 20, seconds value at which the checker aborts an entry; timer saturates here.
- MAX_FAILS, 3, consecutive failed entries that trigger lockout.
- LOCKOUT_S, 30, lockout duration in seconds.
- TIMER_W, 6, width of the seconds counter/timer output; must satisfy 2^TIMER_W > max(ENTRY_TIMEOUT_S, LOCKOUT_S).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- btn0_in, input, 1, raw board button, active-low.
- btn0_out, output, 1, button to checker, active-low; forced 1 (released) during lockout.
- entry_busy, input, 1, checker is in digit-1/2/3-correct states.
- passcode_correct, input, 1, checker success flag.
- timer, output, TIMER_W, elapsed seconds of the current entry, to checker.
- unlocked, output, 1, access granted.
- lockout, output, 1, lockout active.
- fail_count, output, 2, consecutive failures, saturating at MAX_FAILS.

Behaviour:
- Single clock domain; all state async-cleared by rst.
- Reset values: state IDLE, prescaler 0, timer 0, fail_count 0, unlocked 0, lockout 0, btn0_out follows btn0_in.
- Registered outputs: unlocked, lockout, timer, fail_count.
- Combinational output: btn0_out = btn0_in | lockout.
- Second tick:
  - Prescaler counts 0..CLK_HZ-1 and emits a 1-cycle tick on CLK_HZ-1, then wraps to 0.
  - Prescaler and timer clear on every state change.
  - Prescaler is held at 0 in IDLE and UNLOCKED.
- States IDLE, ENTRY, UNLOCKED, LOCKOUT:
  - IDLE: timer=0. entry_busy=1 -> ENTRY next cycle. passcode_correct=1 without a prior entry is ignored.
  - ENTRY: timer increments on each tick and saturates at ENTRY_TIMEOUT_S. Each cycle, first matching rule wins:
    - (a) passcode_correct=1 -> UNLOCKED, fail_count<=0. This covers the cycle where busy falls and correct rises together; success wins.
    - (b) entry_busy=0 and passcode_correct=0 (wrong digit or checker timeout) -> failure. fail_count<=fail_count+1 (saturating). If the new count == MAX_FAILS -> LOCKOUT, else -> IDLE.
    - (c) otherwise stay.
  - UNLOCKED: unlocked=1, timer=0. passcode_correct falling (user confirm press) -> IDLE.
  - LOCKOUT: lockout=1, button masked. timer counts seconds. On the tick that makes timer == LOCKOUT_S -> IDLE, fail_count<=0, lockout<=0.
- Status register timing: unlocked and lockout assert in the first cycle of their state, i.e. one cycle after the triggering input.
- Lockout entry/exit:
  - A button held low across lockout exit appears at btn0_out as a fresh press. The checker one-shot handles this; no extra filtering.
  - On lockout entry, a button held low is released to the checker the same cycle lockout asserts.
- Reset mid-lockout or mid-entry: immediate IDLE, fail_count cleared.
- Timer never wraps; the saturation guards are mandatory.

Decomposition:
- Package passcode_pkg holds:
  - ctrl_state_t enum (IDLE, ENTRY, UNLOCKED, LOCKOUT; 2-bit).
  - Default constants ENTRY_TIMEOUT_S, MAX_FAILS, LOCKOUT_S.
- One sub-module, second_ticker: parameter CLK_HZ; ports clk, rst, clr, en, tick. Prescaler with synchronous clear and enable.

Test Plan (CLK_HZ=4, defaults otherwise):
- Correct entry: entry_busy 1 for 10 cycles, then busy 0 with passcode_correct 1 same cycle -> unlocked=1 next cycle, fail_count=0. Drop passcode_correct -> IDLE, unlocked=0.
- Timer: busy held 1 for 100 cycles -> timer steps 0,1,2… every 4 cycles, saturates at 20, never 21.
- Failure counting: three entries each ending busy 0 with correct 0 -> fail_count 1,2, then lockout=1 on the cycle after the third failure.
- Lockout masking: btn0_in=0 during lockout -> btn0_out=1. Lockout clears exactly 30*4 cycles after entry; fail_count=0; btn0_out follows btn0_in again.
- Failure reset: two failures, then a correct entry -> fail_count 0. Two more failures give no lockout.
- Reset mid-operation: rst pulsed mid-lockout at timer=12 -> lockout=0, timer=0, fail_count=0 immediately (async).

Source files
------------

// File: rtl/passcode_access_ctrl_pkg.sv
// Shared types and default timing constants for the passcode access controller.
package passcode_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTRY    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } ctrl_state_t;

    localparam int ENTRY_TIMEOUT_S = 20;
    localparam int MAX_FAILS       = 3;
    localparam int LOCKOUT_S       = 30;

endpackage

// File: rtl/passcode_access_ctrl_if.sv
// Signals between the board/checker side (master) and the access controller (slave).
interface passcode_access_ctrl_if #(
    parameter int TIMER_W = 6
);
    import passcode_pkg::*;

    // Level signalling only, no valid/ready: every signal is sampled on each rising
    // clk edge and btn0_* are active-low. state is a debug view of the controller FSM.
    logic               btn0_in;
    logic               btn0_out;
    logic               entry_busy;
    logic               passcode_correct;
    logic [TIMER_W-1:0] timer;
    logic               unlocked;
    logic               lockout;
    logic [1:0]         fail_count;
    ctrl_state_t        state;

    modport master (
        output btn0_in, entry_busy, passcode_correct,
        input  btn0_out, timer, unlocked, lockout, fail_count, state
    );

    modport slave (
        input  btn0_in, entry_busy, passcode_correct,
        output btn0_out, timer, unlocked, lockout, fail_count, state
    );

endinterface

// File: rtl/passcode_access_ctrl_second_ticker.sv
// Clock prescaler that emits a one-cycle tick every CLK_HZ enabled cycles.
module second_ticker #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count;

    // tick must not depend on clr: the owner derives clr from a tick-driven transition
    assign tick = en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/passcode_access_ctrl.sv
// Supervises the passcode checker: entry timer, failure counting, timed lockout
// with button masking, and unlocked/lockout status.
module passcode_access_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int ENTRY_TIMEOUT_S = passcode_pkg::ENTRY_TIMEOUT_S,
    parameter int MAX_FAILS       = passcode_pkg::MAX_FAILS,
    parameter int LOCKOUT_S       = passcode_pkg::LOCKOUT_S,
    parameter int TIMER_W         = 6
) (
    input logic                   clk,
    input logic                   rst,
    passcode_access_ctrl_if.slave bus
);
    import passcode_pkg::*;

    localparam logic [TIMER_W-1:0] ENTRY_MAX = TIMER_W'(ENTRY_TIMEOUT_S);
    localparam logic [TIMER_W-1:0] LOCK_MAX  = TIMER_W'(LOCKOUT_S);
    localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCKOUT_S - 1);
    localparam logic [1:0]         FAIL_MAX  = 2'(MAX_FAILS);

    ctrl_state_t        state, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         fail_q, fail_d, fail_inc;
    logic               unlocked_q, unlocked_d;
    logic               lockout_q, lockout_d;
    logic               correct_q;
    logic               tick, changing, tick_en;

    assign fail_inc = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 1'b1;
    assign changing = (state_d != state);
    assign tick_en  = (state == ENTRY) || (state == LOCKOUT);

    second_ticker #(.CLK_HZ(CLK_HZ)) u_ticker (
        .clk  (clk),
        .rst  (rst),
        .clr  (changing || !tick_en),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer_q    <= '0;
            fail_q     <= '0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
            correct_q  <= 1'b0;
        end else begin
            state      <= state_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            unlocked_q <= unlocked_d;
            lockout_q  <= lockout_d;
            correct_q  <= bus.passcode_correct;
        end
    end

    // Success wins over failure when busy falls and correct rises together
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:     if (bus.entry_busy) state_d = ENTRY;
            ENTRY: begin
                if (bus.passcode_correct)  state_d = UNLOCKED;
                else if (!bus.entry_busy)  state_d = (fail_inc == FAIL_MAX) ? LOCKOUT : IDLE;
            end
            UNLOCKED: if (correct_q && !bus.passcode_correct) state_d = IDLE;
            LOCKOUT:  if (tick && (timer_q == LOCK_LAST)) state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_d    = '0;
        fail_d     = fail_q;
        unlocked_d = (state_d == UNLOCKED);
        lockout_d  = (state_d == LOCKOUT);
        if (!changing) begin
            if (state == ENTRY && tick && timer_q < ENTRY_MAX)     timer_d = timer_q + 1'b1;
            else if (state == LOCKOUT && tick && timer_q < LOCK_MAX) timer_d = timer_q + 1'b1;
            else if (state == ENTRY || state == LOCKOUT)           timer_d = timer_q;
        end
        if (state == ENTRY && state_d == UNLOCKED)    fail_d = '0;
        else if (state == ENTRY && changing)          fail_d = fail_inc;
        else if (state == LOCKOUT && changing)        fail_d = '0;
    end

    assign bus.btn0_out   = bus.btn0_in | lockout_q;
    assign bus.timer      = timer_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.lockout    = lockout_q;
    assign bus.fail_count = fail_q;
    assign bus.state      = state;

endmodule
